// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low gfedcba hex patterns and capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SETTLE,
        HELD
    } cap_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse decoder: active-low segment pattern to hex nibble plus hit flag.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (pattern_i)
            SEG_0: nibble_o = 4'h0;
            SEG_1: nibble_o = 4'h1;
            SEG_2: nibble_o = 4'h2;
            SEG_3: nibble_o = 4'h3;
            SEG_4: nibble_o = 4'h4;
            SEG_5: nibble_o = 4'h5;
            SEG_6: nibble_o = 4'h6;
            SEG_7: nibble_o = 4'h7;
            SEG_8: nibble_o = 4'h8;
            SEG_9: nibble_o = 4'h9;
            SEG_A: nibble_o = 4'hA;
            SEG_B: nibble_o = 4'hB;
            SEG_C: nibble_o = 4'hC;
            SEG_D: nibble_o = 4'hD;
            SEG_E: nibble_o = 4'hE;
            SEG_F: nibble_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed active-low 7-segment bus and reassembles the displayed hex word;
// a digit is taken once {an,seg} has been stable for STABLE_CYCLES synchronised samples.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   data,
    output logic                  valid,
    output logic                  err
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
    logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    cap_state_e          state_q;
    logic [7:0]          cnt_q;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                match;
    logic                accept;
    logic                dec_hit;
    logic [3:0]          dec_nib;
    logic [DIGITS-1:0]   sel;
    logic [4*DIGITS-1:0] sel_nib_mask;

    // Idle/blank bus is all ones, so the synchronisers reset to that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            seg_prev_q <= '1;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
        end else begin
            seg_s1_q   <= seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
        end
    end

    assign match  = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);
    assign accept = (state_q == SETTLE) && match && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (!match) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!match) begin
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    seg7_decode u_decode (
        .pattern_i (seg_s2_q),
        .hit_o     (dec_hit),
        .nibble_o  (dec_nib)
    );

    // Selected digit as a one-hot mask, widened to a nibble write mask.
    assign sel = ~an_s2_q;
    for (genvar g = 0; g < DIGITS; g++) begin : g_mask
        assign sel_nib_mask[4*g +: 4] = {4{sel[g]}};
    end

    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (accept && (sel != '0)) begin
            if ($onehot(sel) && dec_hit) begin
                shadow_d = (shadow_q & ~sel_nib_mask) | ({DIGITS{dec_nib}} & sel_nib_mask);
                seen_d   = seen_q | sel;
                if (&seen_d) begin
                    data_d  = shadow_d;
                    valid_d = 1'b1;
                    seen_d  = '0;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            seen_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomised bench for seg7_capture against a run-length based reference model.
module tb_seg7_capture;

    localparam int unsigned S = 4;
    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] data;
    logic        valid;
    logic        err;

    seg7_capture #(
        .DIGITS        (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (seg),
        .an    (an),
        .data  (data),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a pin value held for more than S clock samples is taken once,
    // and its effect shows on the outputs two cycles after the (S+1)-th sample.
    logic [6:0]  hex_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          nib_of [int];
    int          shadow [N];
    logic [7:0]  seen;
    bit          exp_v [int];
    bit          exp_e [int];
    logic [31:0] exp_word [int];
    logic [7:0]  cur_an;
    logic [6:0]  cur_seg;
    int          run_len;
    logic [31:0] mdata = '0;
    int          vcount = 0;
    int          ecount = 0;
    bit          mon_on = 1'b0;

    task automatic model_accept(input int at);
        int idx;
        int lows;
        logic [31:0] word;
        idx  = -1;
        lows = 0;
        if (cur_an == 8'hFF) return;
        for (int i = 0; i < N; i++) begin
            if (!cur_an[i]) begin
                lows++;
                idx = i;
            end
        end
        if (lows != 1 || !nib_of.exists(int'(cur_seg))) begin
            exp_e[at] = 1'b1;
            return;
        end
        shadow[idx] = nib_of[int'(cur_seg)];
        seen[idx]   = 1'b1;
        if (seen == 8'hFF) begin
            word = '0;
            for (int i = 0; i < N; i++) word = word + (32'(shadow[i]) << (4 * i));
            exp_v[at]    = 1'b1;
            exp_word[at] = word;
            seen         = '0;
        end
    endtask

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input int len);
        for (int k = 0; k < len; k++) begin
            an  = a;
            seg = s;
            if (a !== cur_an || s !== cur_seg) begin
                cur_an  = a;
                cur_seg = s;
                run_len = 0;
            end
            @(posedge clk);
            #1;
            run_len++;
            if (run_len == S + 1) model_accept(cyc + 2);
        end
    endtask

    task automatic digit(input int d, input int nib, input int len);
        logic [7:0] a;
        a = ~(8'b1 << d);
        hold(a, hex_seg[nib], len);
    endtask

    task automatic do_reset();
        an    = '1;
        seg   = 7'h7F;
        rst_n = 1'b0;
        exp_v.delete();
        exp_e.delete();
        exp_word.delete();
        for (int i = 0; i < N; i++) shadow[i] = 0;
        seen = '0;
        @(posedge clk);
        #1;
        check_eq("reset_data_now", data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cur_an  = '1;
        cur_seg = 7'h7F;
        run_len = S + 2;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                mdata = '0;
                check_eq("rst_data", data, 32'h0);
                check_eq("rst_valid", 32'(valid), 32'h0);
                check_eq("rst_err", 32'(err), 32'h0);
            end else begin
                if (exp_word.exists(cyc)) mdata = exp_word[cyc];
                check_eq("valid", 32'(valid), exp_v.exists(cyc) ? 32'h1 : 32'h0);
                check_eq("err", 32'(err), exp_e.exists(cyc) ? 32'h1 : 32'h0);
                check_eq("data", data, mdata);
                if (valid) vcount++;
                if (err) ecount++;
            end
        end
    end

    initial begin
        int v0;
        int e0;
        logic [7:0] ra;
        logic [6:0] rs;
        int pick;

        an      = '1;
        seg     = 7'h7F;
        cur_an  = '1;
        cur_seg = 7'h7F;
        run_len = S + 2;
        seen    = '0;
        for (int i = 0; i < 16; i++) nib_of[int'(hex_seg[i])] = i;
        for (int i = 0; i < N; i++) shadow[i] = 0;
        mon_on = 1'b1;
        do_reset();
        check_eq("post_reset_valid", 32'(valid), 32'h0);
        check_eq("post_reset_err", 32'(err), 32'h0);

        // Plain scan, digit 0 shows 8 down to digit 7 showing 1.
        v0 = vcount;
        for (int d = 0; d < N; d++) digit(d, 8 - d, 10);
        check_eq("scan_word", data, 32'h12345678);
        check_eq("scan_valids", 32'(vcount - v0), 32'd1);
        hold(8'hFF, 7'h7F, 6);

        // Long hold on one digit is a single accept.
        v0 = vcount;
        e0 = ecount;
        digit(3, 2, 200);
        check_eq("long_hold_no_valid", 32'(vcount - v0), 32'd0);
        for (int d = 0; d < N; d++) if (d != 3) digit(d, d, 8);
        check_eq("long_hold_word", data, 32'h76542210);
        check_eq("long_hold_valids", 32'(vcount - v0), 32'd1);
        check_eq("long_hold_errs", 32'(ecount - e0), 32'd0);

        // Short glitch of "1" on digit 0 must not be taken.
        hold(8'hFE, 7'h40, 10);
        hold(8'hFE, 7'h79, 2);
        hold(8'hFE, 7'h40, 10);
        for (int d = 1; d < N; d++) digit(d, 10, 8);
        check_eq("glitch_word", data, 32'hAAAAAAA0);

        // Illegal patterns on digit 5 stall completion until a legal one arrives.
        for (int d = 0; d < N; d++) if (d != 5) digit(d, 3, 8);
        v0 = vcount;
        e0 = ecount;
        hold(8'hDF, 7'h7F, 10);
        hold(8'hDF, 7'h5A, 10);
        check_eq("bad_pat_errs", 32'(ecount - e0), 32'd2);
        check_eq("bad_pat_no_valid", 32'(vcount - v0), 32'd0);
        digit(5, 9, 10);
        check_eq("bad_pat_word", data, 32'h33933333);
        check_eq("bad_pat_valids", 32'(vcount - v0), 32'd1);

        // Two digits low is rejected and marks neither as seen; blanking is silent.
        for (int d = 0; d < N; d++) if (d != 2 && d != 3) digit(d, 5, 8);
        v0 = vcount;
        e0 = ecount;
        hold(8'hF3, hex_seg[1], 10);
        check_eq("multi_an_err", 32'(ecount - e0), 32'd1);
        check_eq("multi_an_no_valid", 32'(vcount - v0), 32'd0);
        hold(8'hFF, 7'h7F, 10);
        check_eq("blank_no_err", 32'(ecount - e0), 32'd1);
        check_eq("blank_no_valid", 32'(vcount - v0), 32'd0);
        digit(2, 5, 8);
        digit(3, 5, 8);
        check_eq("multi_an_word", data, 32'h55555555);

        // Reset part way through a frame, then a full frame of F.
        for (int d = 0; d < 5; d++) digit(d, 7, 8);
        digit(5, 7, 3);
        do_reset();
        check_eq("midreset_data", data, 32'h0);
        v0 = vcount;
        for (int d = 0; d < N; d++) digit(d, 15, 8);
        check_eq("after_reset_word", data, 32'hFFFFFFFF);
        check_eq("after_reset_valids", 32'(vcount - v0), 32'd1);

        // Randomised frames and noise.
        for (int f = 0; f < 25; f++) begin
            for (int d = 0; d < N; d++) begin
                digit(d, $urandom_range(0, 15), $urandom_range(S + 1, S + 5));
                if ($urandom_range(0, 3) == 0) hold(8'hFF, 7'h7F, $urandom_range(1, 3));
            end
        end
        for (int r = 0; r < 250; r++) begin
            pick = $urandom_range(0, 9);
            if (pick < 7) ra = ~(8'b1 << $urandom_range(0, 7));
            else if (pick == 7) ra = 8'hFF;
            else ra = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rs = hex_seg[$urandom_range(0, 15)];
            else rs = 7'($urandom);
            hold(ra, rs, $urandom_range(1, S + 4));
        end
        hold(8'hFF, 7'h7F, 10);

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
